// File: rtl/wb_arbiter_marocchino.sv
// Write-back arbiter: picks one ready source per advance (fixed priority or round-robin)
// and registers its result into the write-back stage; counts multi-source conflicts.
module wb_arbiter_marocchino #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
  parameter int unsigned NUM_SRC              = 6,
  parameter string       ARB_MODE             = "PRIORITY"
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          padv_wb_i,
  input  logic                                          pipeline_flush_i,
  input  logic [NUM_SRC-1:0]                            src_rdy_i,
  input  logic [NUM_SRC*OPTION_OPERAND_WIDTH-1:0]       src_result_i,
  input  logic [NUM_SRC*OPTION_RF_ADDR_WIDTH-1:0]       src_rfd_adr_i,
  input  logic [NUM_SRC-1:0]                            src_rf_wb_i,
  input  logic [NUM_SRC-1:0]                            src_except_i,
  output logic [NUM_SRC-1:0]                            src_grant_o,
  output logic                                          wb_valid_o,
  output logic [NUM_SRC-1:0]                            wb_src_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]               wb_result_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]               wb_rfd_adr_o,
  output logic                                          wb_rf_wb_o,
  output logic                                          wb_except_o,
  output logic [15:0]                                   wb_conflicts_o
);

  localparam int unsigned W      = OPTION_OPERAND_WIDTH;
  localparam int unsigned A      = OPTION_RF_ADDR_WIDTH;
  localparam int unsigned N      = NUM_SRC;
  localparam int unsigned PTR_W  = $clog2(NUM_SRC);
  localparam bit          RR_MODE = (ARB_MODE == "ROUND_ROBIN");

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] sel_idx;
  logic [W-1:0]     sel_result;
  logic [A-1:0]     sel_adr;
  logic             sel_rf_wb;
  logic             sel_except;
  logic             arb_en;
  logic             conflict;

  assign arb_en   = ~rst & padv_wb_i & ~pipeline_flush_i & (|src_rdy_i);
  assign conflict = ~rst & padv_wb_i & ~pipeline_flush_i & ($countones(src_rdy_i) > 1);

  // First pass searches from rr_ptr upward, second pass wraps to index 0.
  // In priority mode rr_ptr stays 0, so the first pass is a plain priority search.
  always_comb begin
    logic found;
    found       = 1'b0;
    src_grant_o = '0;
    sel_idx     = '0;
    sel_result  = '0;
    sel_adr     = '0;
    sel_rf_wb   = 1'b0;
    sel_except  = 1'b0;
    if (arb_en) begin
      for (int j = 0; j < int'(N); j++) begin
        if (!found && src_rdy_i[j] && (j >= int'(rr_ptr))) begin
          found          = 1'b1;
          sel_idx        = PTR_W'(j);
          src_grant_o[j] = 1'b1;
        end
      end
      for (int j = 0; j < int'(N); j++) begin
        if (!found && src_rdy_i[j]) begin
          found          = 1'b1;
          sel_idx        = PTR_W'(j);
          src_grant_o[j] = 1'b1;
        end
      end
      for (int j = 0; j < int'(N); j++) begin
        if (src_grant_o[j]) begin
          sel_result = src_result_i[j*int'(W) +: W];
          sel_adr    = src_rfd_adr_i[j*int'(A) +: A];
          sel_rf_wb  = src_rf_wb_i[j] & ~src_except_i[j];
          sel_except = src_except_i[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (RR_MODE && arb_en) begin
      rr_ptr <= (sel_idx == PTR_W'(N - 1)) ? '0 : sel_idx + PTR_W'(1);
    end
  end

  // Flush and empty advance drop the valid/flag state but keep result and address.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o   <= 1'b0;
      wb_src_o     <= '0;
      wb_result_o  <= '0;
      wb_rfd_adr_o <= '0;
      wb_rf_wb_o   <= 1'b0;
      wb_except_o  <= 1'b0;
    end else if (pipeline_flush_i) begin
      wb_valid_o   <= 1'b0;
      wb_src_o     <= '0;
      wb_rf_wb_o   <= 1'b0;
      wb_except_o  <= 1'b0;
    end else if (padv_wb_i) begin
      if (arb_en) begin
        wb_valid_o   <= 1'b1;
        wb_src_o     <= src_grant_o;
        wb_result_o  <= sel_result;
        wb_rfd_adr_o <= sel_adr;
        wb_rf_wb_o   <= sel_rf_wb;
        wb_except_o  <= sel_except;
      end else begin
        wb_valid_o   <= 1'b0;
        wb_src_o     <= '0;
        wb_rf_wb_o   <= 1'b0;
        wb_except_o  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_conflicts_o <= '0;
    end else if (conflict && (wb_conflicts_o != 16'hFFFF)) begin
      wb_conflicts_o <= wb_conflicts_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_marocchino.sv
// Bench for wb_arbiter_marocchino: a priority and a round-robin instance (N=4) on shared inputs.
module tb_wb_arbiter_marocchino;

  logic         clk = 1'b0;
  logic         rst;
  logic         padv;
  logic         flush;
  logic [3:0]   rdy;
  logic [127:0] result;
  logic [19:0]  adr;
  logic [3:0]   rf_wb;
  logic [3:0]   exc;

  logic [3:0]  p_grant, p_src, r_grant, r_src;
  logic        p_valid, p_rfwb, p_exc, r_valid, r_rfwb, r_exc;
  logic [31:0] p_res, r_res;
  logic [4:0]  p_adr, r_adr;
  logic [15:0] p_conf, r_conf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_marocchino #(.OPTION_OPERAND_WIDTH(32), .OPTION_RF_ADDR_WIDTH(5),
                          .NUM_SRC(4), .ARB_MODE("PRIORITY")) u_prio (
    .clk(clk), .rst(rst), .padv_wb_i(padv), .pipeline_flush_i(flush),
    .src_rdy_i(rdy), .src_result_i(result), .src_rfd_adr_i(adr),
    .src_rf_wb_i(rf_wb), .src_except_i(exc), .src_grant_o(p_grant),
    .wb_valid_o(p_valid), .wb_src_o(p_src), .wb_result_o(p_res),
    .wb_rfd_adr_o(p_adr), .wb_rf_wb_o(p_rfwb), .wb_except_o(p_exc),
    .wb_conflicts_o(p_conf));

  wb_arbiter_marocchino #(.OPTION_OPERAND_WIDTH(32), .OPTION_RF_ADDR_WIDTH(5),
                          .NUM_SRC(4), .ARB_MODE("ROUND_ROBIN")) u_rr (
    .clk(clk), .rst(rst), .padv_wb_i(padv), .pipeline_flush_i(flush),
    .src_rdy_i(rdy), .src_result_i(result), .src_rfd_adr_i(adr),
    .src_rf_wb_i(rf_wb), .src_except_i(exc), .src_grant_o(r_grant),
    .wb_valid_o(r_valid), .wb_src_o(r_src), .wb_result_o(r_res),
    .wb_rfd_adr_o(r_adr), .wb_rf_wb_o(r_rfwb), .wb_except_o(r_exc),
    .wb_conflicts_o(r_conf));

  typedef struct packed {
    logic        rst;
    logic        padv;
    logic        flush;
    logic [3:0]  rdy;
    logic [3:0]  rf_wb;
    logic [3:0]  exc;
    logic [3:0]  grant;
    logic        valid;
    logic [3:0]  src;
    logic [31:0] res;
    logic [4:0]  adr;
    logic        rfwb;
    logic        wexc;
    logic [15:0] conf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // source k: result A000_000k, destination address k+1
    for (int k = 0; k < 4; k++) begin
      result[k*32 +: 32] = 32'hA000_0000 + 32'(k);
      adr[k*5 +: 5]      = 5'(k + 1);
    end
    rst = 1'b1; padv = 1'b0; flush = 1'b0; rdy = '0; rf_wb = 4'b1111; exc = '0;

    //                 rst   padv  flush rdy      rf_wb    exc      grant    vld   src      res            adr    rfwb  wexc  conf
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'b1010, 4'b1111, 4'b0000, 4'b0010, 1'b1, 4'b0010, 32'hA000_0001, 5'd2, 1'b1, 1'b0, 16'd1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'hA000_0001, 5'd2, 1'b0, 1'b0, 16'd1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0100, 4'b0100, 1'b1, 4'b0100, 32'hA000_0002, 5'd3, 1'b0, 1'b1, 16'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'b1100, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0100, 32'hA000_0002, 5'd3, 1'b0, 1'b1, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'b1100, 4'b1111, 4'b0000, 4'b0100, 1'b1, 4'b0100, 32'hA000_0002, 5'd3, 1'b1, 1'b0, 16'd2};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'hA000_0002, 5'd3, 1'b0, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'hA000_0002, 5'd3, 1'b0, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b1, 4'b0001, 32'hA000_0000, 5'd1, 1'b1, 1'b0, 16'd3};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'b1000, 4'b0111, 4'b0000, 4'b1000, 1'b1, 4'b1000, 32'hA000_0003, 5'd4, 1'b0, 1'b0, 16'd3};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 4'b0001, 1'b1, 4'b0001, 32'hA000_0000, 5'd1, 1'b1, 1'b0, 16'd0};

    tick(); tick();
    chk("reset_valid", 32'(p_valid), 32'd0);
    chk("reset_src", 32'(p_src), 32'd0);
    chk("reset_result", p_res, 32'd0);
    chk("reset_conf", 32'(p_conf), 32'd0);
    chk("reset_grant", 32'(p_grant), 32'd0);
    rst = 1'b0;

    // Priority instance: table
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; padv = vecs[i].padv; flush = vecs[i].flush;
      rdy = vecs[i].rdy; rf_wb = vecs[i].rf_wb; exc = vecs[i].exc;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(p_grant), 32'(vecs[i].grant));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(p_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_src", i), 32'(p_src), 32'(vecs[i].src));
      chk($sformatf("v%0d_result", i), p_res, vecs[i].res);
      chk($sformatf("v%0d_adr", i), 32'(p_adr), 32'(vecs[i].adr));
      chk($sformatf("v%0d_rf_wb", i), 32'(p_rfwb), 32'(vecs[i].rfwb));
      chk($sformatf("v%0d_except", i), 32'(p_exc), 32'(vecs[i].wexc));
      chk($sformatf("v%0d_conf", i), 32'(p_conf), 32'(vecs[i].conf));
    end

    // Round-robin rotation with wrap
    rst = 1'b1; padv = 1'b0; flush = 1'b0; rdy = '0; rf_wb = 4'b1111; exc = '0;
    tick();
    rst = 1'b0; padv = 1'b1; rdy = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr%0d_grant", i), 32'(r_grant), 32'(4'b0001 << (i % 4)));
      tick();
      chk($sformatf("rr%0d_src", i), 32'(r_src), 32'(4'b0001 << (i % 4)));
      chk($sformatf("rr%0d_result", i), r_res, 32'hA000_0000 + 32'(i % 4));
    end
    chk("rr_conf5", 32'(r_conf), 32'd5);

    // Pointer now 1; granting source 2 moves it to 3
    rdy = 4'b0100;
    #1;
    chk("rr_grant_src2", 32'(r_grant), 32'(4'b0100));
    tick();

    // Reset with pointer at 3: outputs cleared, no grant, pointer back to 0
    rst = 1'b1; rdy = 4'b1001;
    #1;
    chk("rr_rst_grant", 32'(r_grant), 32'd0);
    tick();
    chk("rr_rst_valid", 32'(r_valid), 32'd0);
    chk("rr_rst_src", 32'(r_src), 32'd0);
    chk("rr_rst_result", r_res, 32'd0);
    chk("rr_rst_conf", 32'(r_conf), 32'd0);
    rst = 1'b0;
    #1;
    chk("rr_post_rst_grant", 32'(r_grant), 32'(4'b0001));
    tick();
    chk("rr_post_rst_src", 32'(r_src), 32'(4'b0001));
    chk("rr_post_rst_valid", 32'(r_valid), 32'd1);

    // Flush does not move the pointer: 1001 with ptr=1 then flush, next grant is source 3
    rdy = 4'b0001;
    tick();
    flush = 1'b1; rdy = 4'b1111;
    #1;
    chk("rr_flush_grant", 32'(r_grant), 32'd0);
    tick();
    flush = 1'b0; rdy = 4'b1001;
    #1;
    chk("rr_after_flush_grant", 32'(r_grant), 32'(4'b1000));

    // Conflict counter saturation
    rst = 1'b1; padv = 1'b0; rdy = '0;
    tick();
    rst = 1'b0; padv = 1'b1; rdy = 4'b0011;
    repeat (65534) @(posedge clk);
    #1;
    chk("conf_preload", 32'(p_conf), 32'h0000_FFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("conf_saturate", 32'(p_conf), 32'h0000_FFFF);
    tick();
    chk("conf_hold", 32'(p_conf), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
